// File: rtl/output_bcd_display_if.sv
// Bus between the CPU output register and the BCD display block.
interface output_bcd_display_if;
  // load is a one-cycle strobe that is always accepted: there is no ready. A load
  // during a conversion goes to a 1-deep pending slot, where a newer load replaces it.
  logic [7:0]  value;
  logic        load;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  digit_sel;
  logic        dbg_conv;

  modport master (
    output value, load,
    input  busy, bcd, seg, digit_sel, dbg_conv
  );

  modport slave (
    input  value, load,
    output busy, bcd, seg, digit_sel, dbg_conv
  );
endinterface

// File: rtl/output_bcd_display.sv
// Captures the output register, converts it to BCD one bit per clock with double-dabble,
// and scans the three digits onto a multiplexed 7-segment display.
module output_bcd_display #(
  parameter int DIV_BITS = 10,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output_bcd_display_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [19:0]          r_work;
  logic [19:0]          w_adj;
  logic [2:0]           r_cnt;
  logic                 r_pend;
  logic [7:0]           r_pend_val;
  logic [11:0]          r_bcd;
  logic [DIV_BITS-1:0]  r_presc;
  logic [1:0]           r_idx;
  logic [6:0]           r_seg;
  logic [2:0]           r_sel;
  logic                 w_start;
  logic                 w_done;
  logic                 w_busy;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic [6:0]           w_seg_code;
  logic [2:0]           w_sel_code;

  assign w_start = (r_state == S_IDLE) && (bus.load || r_pend);
  assign w_done  = (r_state == S_CONV) && (r_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.load || r_pend) w_next_state = S_CONV;
      S_CONV:  if (r_cnt == 3'd7)      w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state == S_CONV);
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 3; i++) begin
      if (r_work[8+4*i +: 4] >= 4'd5) w_adj[8+4*i +: 4] = r_work[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_bcd      <= '0;
    end else if (w_start) begin
      r_work <= {12'h000, (bus.load ? bus.value : r_pend_val)};
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (r_state == S_CONV) begin
      r_work <= {w_adj[18:0], 1'b0};
      r_cnt  <= r_cnt + 3'd1;
      if (w_done) r_bcd <= w_adj[18:7];
      if (bus.load) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.value;
      end
    end
  end

  always_comb begin
    w_digit    = 4'd0;
    w_sel_code = 3'b001;
    w_blank    = 1'b0;
    case (r_idx)
      2'd0: begin
        w_digit    = r_bcd[3:0];
        w_sel_code = 3'b001;
      end
      2'd1: begin
        w_digit    = r_bcd[7:4];
        w_sel_code = 3'b010;
        w_blank    = BLANK_LZ && (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_digit    = r_bcd[11:8];
        w_sel_code = 3'b100;
        w_blank    = BLANK_LZ && (r_bcd[11:8] == 4'd0);
      end
      default: begin
        w_digit    = 4'd0;
        w_sel_code = 3'b001;
        w_blank    = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg_code = 7'h3F;
      4'd1:    w_seg_code = 7'h06;
      4'd2:    w_seg_code = 7'h5B;
      4'd3:    w_seg_code = 7'h4F;
      4'd4:    w_seg_code = 7'h66;
      4'd5:    w_seg_code = 7'h6D;
      4'd6:    w_seg_code = 7'h7D;
      4'd7:    w_seg_code = 7'h07;
      4'd8:    w_seg_code = 7'h7F;
      4'd9:    w_seg_code = 7'h6F;
      default: w_seg_code = 7'h00;
    endcase
  end

  // Outputs are registered from the current index, so they trail it by one clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_sel   <= 3'b001;
      r_seg   <= 7'h00;
    end else begin
      r_presc <= r_presc + DIV_BITS'(1);
      if (&r_presc) r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      r_sel <= w_sel_code;
      r_seg <= w_blank ? 7'h00 : w_seg_code;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.dbg_conv  = (r_state == S_CONV);
  assign bus.bcd       = r_bcd;
  assign bus.seg       = r_seg;
  assign bus.digit_sel = r_sel;

endmodule
